// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch sequencer.
//   state_e           fetch FSM states
//   OP_BRA / OP_BRC   branch opcodes (unconditional / flag-conditional)
//   HALT_WORD         the all-zero instruction word
//   *_MSB/_LSB/_BIT   instruction field positions: op[8:6], dir[5], off[4:0]
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_FILL,
        ST_RUN,
        ST_HALT
    } state_e;

    localparam logic [2:0] OP_BRA    = 3'b111;
    localparam logic [2:0] OP_BRC    = 3'b110;
    localparam logic [8:0] HALT_WORD = 9'h000;

    localparam int OP_MSB  = 8;
    localparam int OP_LSB  = 6;
    localparam int DIR_BIT = 5;
    localparam int OFF_MSB = 4;
    localparam int OFF_LSB = 0;

endpackage

// File: rtl/branch_tgt.sv
// branch_tgt: turns a decoded branch (dir/off) into pc control signals.
//   taken_i    branch resolved taken this cycle
//   dir_i      1 = backward
//   off_i      offset magnitude
//   branchf_o  forward request to pc
//   branchb_o  backward request to pc
//   target_o   value for pc target_i
// pc computes pc+1+target (forward) or pc+1-target (backward), and at decode
// pc already points at branch_addr+1, so the +1 is pre-compensated here.
module branch_tgt #(
    parameter int ADDR_W = 8,
    parameter int OFF_W  = 5
) (
    input  logic              taken_i,
    input  logic              dir_i,
    input  logic [OFF_W-1:0]  off_i,
    output logic              branchf_o,
    output logic              branchb_o,
    output logic [ADDR_W-1:0] target_o
);

    logic [ADDR_W-1:0] off_ext;

    assign off_ext   = ADDR_W'(off_i);
    assign branchf_o = taken_i & ~dir_i;
    assign branchb_o = taken_i &  dir_i;
    // off=0 forward wraps to all-ones, which re-fetches branch_addr+1.
    assign target_o  = dir_i ? off_ext + ADDR_W'(1) : off_ext - ADDR_W'(1);

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer sitting downstream of pc and driving its controls.
//   clock_i, reset_i      clock, synchronous active-high reset
//   go_i, start_addr_i    (re)start request and program start address
//   imem_data_i           sync ROM word for the previous cycle's pc_o
//   flag_i                condition for BRC, sampled at decode
//   pc_start_o, pc_startadd_o, pc_branchf_o, pc_branchb_o, pc_target_o
//                         combinational controls into pc
//   instr_o, instr_valid_o  registered instruction stream to decode
//   halted_o              registered, high while halted
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 9,
    parameter int OFF_W   = 5
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               go_i,
    input  logic [ADDR_W-1:0]  start_addr_i,
    input  logic [INSTR_W-1:0] imem_data_i,
    input  logic               flag_i,
    output logic               pc_start_o,
    output logic [ADDR_W-1:0]  pc_startadd_o,
    output logic               pc_branchf_o,
    output logic               pc_branchb_o,
    output logic [ADDR_W-1:0]  pc_target_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               instr_valid_o,
    output logic               halted_o
);

    state_e             state_q;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;
    logic               halted_q;
    logic               squash_q;
    logic [ADDR_W-1:0]  startadd_q;

    // Decode of the word currently on the memory bus.
    logic [2:0]         op;
    logic               is_halt;
    logic               is_brc;
    logic               taken;
    logic               run_dec;
    logic               hold;
    logic               bt_f;
    logic               bt_b;
    logic [ADDR_W-1:0]  bt_tgt;

    assign op      = imem_data_i[OP_MSB:OP_LSB];
    assign is_halt = (imem_data_i == HALT_WORD);
    assign is_brc  = (op == OP_BRC);
    assign taken   = (op == OP_BRA) | (is_brc & flag_i);

    // A live decode only happens in RUN when no restart and no squash is pending.
    assign run_dec = (state_q == ST_RUN) && !go_i && !squash_q;
    assign hold    = (state_q == ST_IDLE) || (state_q == ST_HALT) ||
                     (run_dec && is_halt);

    branch_tgt #(
        .ADDR_W (ADDR_W),
        .OFF_W  (OFF_W)
    ) u_branch_tgt (
        .taken_i   (taken),
        .dir_i     (imem_data_i[DIR_BIT]),
        .off_i     (imem_data_i[OFF_W-1:0]),
        .branchf_o (bt_f),
        .branchb_o (bt_b),
        .target_o  (bt_tgt)
    );

    // pc always advances; holding it means stepping back by one.
    always_comb begin
        pc_start_o   = 1'b0;
        pc_branchf_o = 1'b0;
        pc_branchb_o = 1'b0;
        pc_target_o  = '0;
        if (reset_i || hold) begin
            pc_branchb_o = 1'b1;
            pc_target_o  = ADDR_W'(1);
        end else if (state_q == ST_START) begin
            pc_start_o   = 1'b1;
        end else if (run_dec && taken) begin
            pc_branchf_o = bt_f;
            pc_branchb_o = bt_b;
            pc_target_o  = bt_tgt;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            squash_q   <= 1'b0;
            startadd_q <= '0;
        end else if (go_i) begin
            // Restart wins over anything decoded this cycle.
            state_q    <= ST_START;
            startadd_q <= start_addr_i;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            squash_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE:  ;
                ST_START: state_q <= ST_FILL;
                ST_FILL:  state_q <= ST_RUN;
                ST_RUN: begin
                    if (squash_q) begin
                        squash_q <= 1'b0;          // wrong-path word dropped
                    end else if (is_halt) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else if (taken) begin
                        squash_q <= 1'b1;
                    end else if (!is_brc) begin
                        instr_q  <= imem_data_i;   // untaken BRC falls through unseen
                        valid_q  <= 1'b1;
                    end
                end
                ST_HALT:  ;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign halted_o      = halted_q;
    assign pc_startadd_o = startadd_q;

endmodule
